i2c_slave_fsm: RTL and testbench

- I2C target (responder) for the master datapath: answers a single 7-bit address, receives write bytes and returns read bytes.
- Oversamples the bus SCL/SDA on the system clock and detects START and STOP conditions.
- Drives SDA open-drain (pull-low only) for ACK and read data.
- Exchanges bytes with the local register side through simple valid/ready pulses.

---
 rtl/i2c_slave_fsm.sv | 207 ++++++++++++++++++++
 tb/tb_i2c_slave_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module   : i2c_slave_fsm
// Purpose  : I2C target with one 7-bit address; oversampled SCL/SDA,
//            open-drain SDA drive, valid/ready byte exchange.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module i2c_slave_fsm #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         ADDR_LEN   = 7,
    parameter int         DATA_LEN   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE           = 4'd0,
        RECV_ADDRESS   = 4'd1,
        SEND_ACK_ADDR  = 4'd2,
        READ_DATA      = 4'd3,
        SEND_ACK_DATA  = 4'd4,
        WRITE_DATA     = 4'd5,
        CHECK_ACK_DATA = 4'd6,
        WAIT_STOP      = 4'd7
    } state_t;

    localparam logic [3:0] ADDR_BITS = 4'(ADDR_LEN + 1);
    localparam logic [3:0] BYTE_BITS = 4'(DATA_LEN);
    localparam logic [3:0] LAST_BIT  = 4'(DATA_LEN - 1);

    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       scl_rise, scl_fall, start_cond, stop_cond;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] rx_data_n;
    logic [7:0] load_byte;
    logic       oe_n, rx_valid_n, tx_ready_n, addr_match_n, rw_n;

    // Two-flop synchronizer plus one history flop per line
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
        end else begin
            scl_s1 <= scl_in; scl_s2 <= scl_s1; scl_d <= scl_s2;
            sda_s1 <= sda_in; sda_s2 <= sda_s1; sda_d <= sda_s2;
        end
    end

    assign scl_rise   = scl_s2 & ~scl_d;
    assign scl_fall   = ~scl_s2 & scl_d;
    assign start_cond = scl_s2 & sda_d & ~sda_s2;
    assign stop_cond  = scl_s2 & ~sda_d & sda_s2;
    assign load_byte  = tx_valid ? tx_data : 8'hFF;
    assign busy       = (state != IDLE) && (state != WAIT_STOP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            shift      <= 8'h00;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_ready   <= 1'b0;
            addr_match <= 1'b0;
            rw         <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            shift      <= shift_n;
            sda_oe     <= oe_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
            tx_ready   <= tx_ready_n;
            addr_match <= addr_match_n;
            rw         <= rw_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        shift_n      = shift;
        oe_n         = sda_oe;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
        tx_ready_n   = 1'b0;
        addr_match_n = 1'b0;
        rw_n         = rw;
        // Bus conditions preempt any bit activity in the same cycle
        if (stop_cond) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            cnt_n   = 4'd0;
        end else if (start_cond) begin
            state_n = RECV_ADDRESS;
            oe_n    = 1'b0;
            cnt_n   = 4'd0;
        end else begin
            case (state)
                IDLE: ;
                RECV_ADDRESS: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s2};
                        cnt_n   = cnt + 4'd1;
                    end else if (scl_fall && cnt == ADDR_BITS) begin
                        cnt_n = 4'd0;
                        if (shift[ADDR_LEN:1] == SLAVE_ADDR) begin
                            rw_n         = shift[0];
                            oe_n         = 1'b1;
                            addr_match_n = 1'b1;
                            state_n      = SEND_ACK_ADDR;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = WAIT_STOP;
                        end
                    end
                end
                SEND_ACK_ADDR: begin
                    if (scl_fall) begin
                        cnt_n = 4'd0;
                        if (!rw) begin
                            oe_n    = 1'b0;
                            state_n = READ_DATA;
                        end else begin
                            shift_n    = load_byte;
                            tx_ready_n = tx_valid;
                            oe_n       = ~load_byte[7];
                            state_n    = WRITE_DATA;
                        end
                    end
                end
                READ_DATA: begin
                    if (scl_rise) begin
                        shift_n = {shift[6:0], sda_s2};
                        cnt_n   = cnt + 4'd1;
                        if (cnt == LAST_BIT) begin
                            rx_data_n  = {shift[6:0], sda_s2};
                            rx_valid_n = 1'b1;
                        end
                    end else if (scl_fall && cnt == BYTE_BITS) begin
                        oe_n    = 1'b1;
                        cnt_n   = 4'd0;
                        state_n = SEND_ACK_DATA;
                    end
                end
                SEND_ACK_DATA: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = READ_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (scl_fall) begin
                        if (cnt == LAST_BIT) begin
                            oe_n    = 1'b0;
                            cnt_n   = 4'd0;
                            state_n = CHECK_ACK_DATA;
                        end else begin
                            cnt_n   = cnt + 4'd1;
                            shift_n = {shift[6:0], 1'b0};
                            oe_n    = ~shift[6];
                        end
                    end
                end
                CHECK_ACK_DATA: begin
                    // A fall here always follows an ACKed rise; NACK leaves on the rise
                    if (scl_rise && sda_s2) begin
                        cnt_n   = 4'd0;
                        state_n = WAIT_STOP;
                    end else if (scl_fall) begin
                        shift_n    = load_byte;
                        tx_ready_n = tx_valid;
                        oe_n       = ~load_byte[7];
                        cnt_n      = 4'd0;
                        state_n    = WRITE_DATA;
                    end
                end
                WAIT_STOP: oe_n = 1'b0;
                default: begin
                    state_n = IDLE;
                    oe_n    = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_slave_fsm
// Purpose  : Bus-master model with event scoreboard for i2c_slave_fsm.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_slave_fsm;

    localparam logic [1:0] K_ADDR = 2'd0;
    localparam logic [1:0] K_RX   = 2'd1;
    localparam logic [1:0] K_TX   = 2'd2;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       rw;
    logic       busy;

    int  vectors    = 0;
    int  miscompares = 0;
    ev_t sb[$];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl),
        .sda_in     (sda_bus),
        .sda_oe     (sda_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .rw         (rw),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [1:0] kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb.push_back(e);
    endfunction

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] data, input string name);
        ev_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected pulse, data %h, scoreboard empty", name, data);
        end else begin
            e = sb.pop_front();
            if (e.kind !== kind || e.data !== data) begin
                miscompares++;
                $display("FAIL %s: got kind %0d data %h, expected kind %0d data %h",
                         name, kind, data, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every output pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_match) expect_ev(K_ADDR, {7'b0, rw}, "addr_match");
            if (rx_valid)   expect_ev(K_RX, rx_data, "rx_valid");
            if (tx_ready)   expect_ev(K_TX, {7'b0, sda_oe}, "tx_ready");
        end
    end

    task automatic qtr();
        repeat (6) @(posedge clk);
        #2;
    endtask

    task automatic bus_start();
        sda_m = 1'b1; qtr();
        scl   = 1'b1; qtr();
        sda_m = 1'b0; qtr();
        scl   = 1'b0; qtr();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; qtr();
        scl   = 1'b1; qtr();
        sda_m = 1'b1; qtr();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; qtr();
        scl = 1'b1; qtr(); qtr();
        scl = 1'b0; qtr();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qtr();
        scl = 1'b1; qtr();
        b = sda_bus; qtr();
        scl = 1'b0; qtr();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(a);
        check(name, {7'b0, a}, {7'b0, exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack,
                             input logic [7:0] nxt_data, input logic nxt_valid,
                             input string name);
        logic [7:0] got;
        for (int i = 7; i >= 0; i--) read_bit(got[i]);
        check(name, got, exp);
        tx_data  = nxt_data;
        tx_valid = nxt_valid;
        write_bit(nack);
    endtask

    initial begin
        logic [7:0] a0;
        a0       = 8'hA0;
        rst      = 1'b1;
        scl      = 1'b1;
        sda_m    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sda_oe", {7'b0, sda_oe}, 8'h00);
        check("reset_pulses", {5'b0, rx_valid, tx_ready, addr_match}, 8'h00);
        check("reset_rw_busy", {6'b0, rw, busy}, 8'h00);
        check("reset_rx_data", rx_data, 8'h00);
        @(negedge clk) rst = 1'b0;
        qtr();

        // Master write of one byte
        push(K_ADDR, 8'h00);
        push(K_RX, 8'h3C);
        bus_start();
        write_byte(8'hA0, 1'b0, "wr_addr_ack");
        write_byte(8'h3C, 1'b0, "wr_data_ack");
        bus_stop();
        check("wr_busy_after_stop", {7'b0, busy}, 8'h00);
        check("wr_rx_data_held", rx_data, 8'h3C);

        // Single-byte read, master NACK
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        push(K_ADDR, 8'h01);
        push(K_TX, 8'h00);
        bus_start();
        write_byte(8'hA1, 1'b0, "rd1_addr_ack");
        read_byte(8'h96, 1'b1, 8'h00, 1'b0, "rd1_byte");
        check("rd1_wait_stop_busy", {7'b0, busy}, 8'h00);
        check("rd1_wait_stop_oe", {7'b0, sda_oe}, 8'h00);
        bus_stop();

        // Three-byte read, empty source on the last byte
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        push(K_ADDR, 8'h01);
        push(K_TX, 8'h01);
        push(K_TX, 8'h01);
        bus_start();
        write_byte(8'hA1, 1'b0, "rd3_addr_ack");
        read_byte(8'h11, 1'b0, 8'h22, 1'b1, "rd3_byte0");
        read_byte(8'h22, 1'b0, 8'h77, 1'b0, "rd3_byte1");
        read_byte(8'hFF, 1'b1, 8'h00, 1'b0, "rd3_byte2_empty");
        bus_stop();

        // Foreign address is ignored until STOP
        bus_start();
        write_byte(8'hA2, 1'b1, "foreign_addr_nack");
        write_byte(8'h55, 1'b1, "foreign_data_nack");
        check("foreign_busy", {7'b0, busy}, 8'h00);
        bus_stop();

        // Partial write byte dropped by repeated START
        push(K_ADDR, 8'h00);
        bus_start();
        write_byte(8'hA0, 1'b0, "rs_wr_addr_ack");
        write_bit(1'b1);
        write_bit(1'b0);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        push(K_ADDR, 8'h01);
        push(K_TX, 8'h01);
        bus_start();
        write_byte(8'hA1, 1'b0, "rs_rd_addr_ack");
        check("rs_rw", {7'b0, rw}, 8'h01);
        read_byte(8'h5A, 1'b1, 8'h00, 1'b0, "rs_rd_byte");
        bus_stop();
        check("rs_rx_data_kept", rx_data, 8'h3C);

        // Reset while ACK is being driven
        tx_valid = 1'b0;
        push(K_ADDR, 8'h00);
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(a0[i]);
        check("rst_ack_driven", {7'b0, sda_oe}, 8'h01);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sda_released", {7'b0, sda_oe}, 8'h00);
        check("rst_busy_rw", {6'b0, busy, rw}, 8'h00);
        check("rst_rx_data", rx_data, 8'h00);
        @(negedge clk) rst = 1'b0;
        qtr();
        bus_stop();
        check("rst_idle_after_stop", {7'b0, busy}, 8'h00);

        qtr();
        check("scoreboard_drained", 8'(sb.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
